// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage of the 5-stage ARM pipeline. Owns
//                the PC and the IF/ID pipeline register. It drives the
//                instruction RAM address, computes PC+4, and latches the
//                fetched word into IF/ID. Hazard detection can stall the
//                stage. A taken branch resolved in ID redirects the PC and
//                squashes the wrong-path fetch into a NOP bubble.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC     PC value loaded on reset
//    CNT_W        width of the saturating fetched-instruction counter
//  Ports
//    CLK          clock; all state updates on the rising edge
//    CLR          synchronous active-high reset
//    stall        hold PC and IF/ID this cycle
//    br_taken     branch in ID resolved taken this cycle
//    br_target    branch target byte address (low two bits ignored)
//    imem_data    instruction word from the combinational instruction RAM
//    imem_addr    instruction RAM address (equals pc)
//    pc           current PC
//    ifid_inst    IF/ID instruction word (all zeros is a NOP)
//    ifid_pc4     PC+4 of the instruction held in IF/ID
//    ifid_valid   IF/ID holds a real fetched instruction
//    fetch_count  instructions accepted into IF/ID, saturating
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_inst,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count
);

    // Per-edge action, decoded from the control inputs in priority order.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_HOLD     = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_RESET    = 2'd3
    } action_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;
    // Word-alignment mask for branch targets.
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_inst;
    logic [31:0]      r_ifid_pc4;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_fetch_count;

    action_t          w_action;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_target_aligned;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_cnt_next;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    // Wraps modulo 2^32, so 32'hFFFFFFFC steps to 0.
    assign w_pc_plus4       = r_pc + c_PC_STEP;
    assign w_target_aligned = br_target & c_ALIGN_MASK;
    assign w_cnt_full       = &r_fetch_count;
    assign w_cnt_next       = w_cnt_full ? r_fetch_count
                                         : r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};

    // A stalled branch is not final yet, so the redirect only wins when the
    // stage is not stalled. Reset overrides everything.
    always_comb begin
        w_action = ACT_ADVANCE;
        if (CLR) begin
            w_action = ACT_RESET;
        end else if (br_taken && !stall) begin
            w_action = ACT_REDIRECT;
        end else if (stall) begin
            w_action = ACT_HOLD;
        end
    end

    // ------------------------------------------------------------------------
    // PC and IF/ID register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        case (w_action)
            ACT_RESET: begin
                r_pc          <= RESET_PC;
                r_ifid_inst   <= 32'h0;
                r_ifid_pc4    <= 32'h0;
                r_ifid_valid  <= 1'b0;
                r_fetch_count <= '0;
            end
            ACT_REDIRECT: begin
                // The word on imem_data is wrong-path; insert one bubble.
                r_pc          <= w_target_aligned;
                r_ifid_inst   <= 32'h0;
                r_ifid_pc4    <= 32'h0;
                r_ifid_valid  <= 1'b0;
            end
            ACT_HOLD: begin
                r_pc          <= r_pc;
                r_ifid_inst   <= r_ifid_inst;
                r_ifid_pc4    <= r_ifid_pc4;
                r_ifid_valid  <= r_ifid_valid;
                r_fetch_count <= r_fetch_count;
            end
            default: begin
                // A zero word fetched here is a genuine NOP: valid and counted.
                r_pc          <= w_pc_plus4;
                r_ifid_inst   <= imem_data;
                r_ifid_pc4    <= w_pc_plus4;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= w_cnt_next;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign ifid_inst   = r_ifid_inst;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. Two instances share
//                the control inputs: one with default parameters and one
//                with RESET_PC=32'hFFFFFFFC, CNT_W=2 for wrap and saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    logic [31:0] mem [64];

    logic [31:0] w_imem_data0, w_imem_addr0, w_pc0, w_inst0, w_pc4_0;
    logic        w_valid0;
    logic [15:0] w_cnt0;
    logic [31:0] w_imem_data1, w_imem_addr1, w_pc1, w_inst1, w_pc4_1;
    logic        w_valid1;
    logic [1:0]  w_cnt1;

    always #5 CLK = ~CLK;

    // Combinational instruction RAM, addressed by word.
    assign w_imem_data0 = mem[w_imem_addr0[7:2]];
    assign w_imem_data1 = mem[w_imem_addr1[7:2]];

    fetch_stage dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_data  (w_imem_data0),
        .imem_addr  (w_imem_addr0),
        .pc         (w_pc0),
        .ifid_inst  (w_inst0),
        .ifid_pc4   (w_pc4_0),
        .ifid_valid (w_valid0),
        .fetch_count(w_cnt0)
    );

    fetch_stage #(
        .RESET_PC(32'hFFFF_FFFC),
        .CNT_W   (2)
    ) dut_w (
        .CLK        (CLK),
        .CLR        (CLR),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_data  (w_imem_data1),
        .imem_addr  (w_imem_addr1),
        .pc         (w_pc1),
        .ifid_inst  (w_inst1),
        .ifid_pc4   (w_pc4_1),
        .ifid_valid (w_valid1),
        .fetch_count(w_cnt1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per instance.
    logic [31:0] m_pc   [2];
    logic [31:0] m_inst [2];
    logic [31:0] m_pc4  [2];
    logic [31:0] m_valid[2];
    int          m_cnt  [2];
    int          cap    [2] = '{65535, 3};
    logic [31:0] rst_pc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input logic c, input logic s,
                              input logic b, input logic [31:0] t);
        if (c) begin
            m_pc[i] = rst_pc[i]; m_inst[i] = 0; m_pc4[i] = 0; m_valid[i] = 0; m_cnt[i] = 0;
        end else if (b && !s) begin
            m_pc[i] = {t[31:2], 2'b00}; m_inst[i] = 0; m_pc4[i] = 0; m_valid[i] = 0;
        end else if (!s) begin
            m_inst[i]  = mem[m_pc[i][7:2]];
            m_pc[i]    = m_pc[i] + 32'd4;
            m_pc4[i]   = m_pc[i];
            m_valid[i] = 1;
            if (m_cnt[i] < cap[i]) m_cnt[i]++;
        end
    endtask

    task automatic step(input logic c, input logic s, input logic b, input logic [31:0] t);
        @(negedge CLK);
        CLR = c; stall = s; br_taken = b; br_target = t;
        model_edge(0, c, s, b, t);
        model_edge(1, c, s, b, t);
        @(posedge CLK);
        #1;
        chk("pc0",    w_pc0,        m_pc[0]);
        chk("addr0",  w_imem_addr0, m_pc[0]);
        chk("inst0",  w_inst0,      m_inst[0]);
        chk("pc4_0",  w_pc4_0,      m_pc4[0]);
        chk("valid0", {31'b0, w_valid0}, m_valid[0]);
        chk("cnt0",   {16'b0, w_cnt0},   32'(m_cnt[0]));
        chk("pc1",    w_pc1,        m_pc[1]);
        chk("inst1",  w_inst1,      m_inst[1]);
        chk("pc4_1",  w_pc4_1,      m_pc4[1]);
        chk("valid1", {31'b0, w_valid1}, m_valid[1]);
        chk("cnt1",   {30'b0, w_cnt1},   32'(m_cnt[1]));
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i % 7 == 5) ? 32'h0 : $urandom;
        mem[0] = 32'hE3A0_0001;
        mem[1] = 32'hE3A0_1002;
        mem[2] = 32'hE081_2000;

        // Reset held for two edges, then free-run.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_pc",    w_pc0, 32'h0);
        chk("rst_valid", {31'b0, w_valid0}, 32'h0);
        adv(1);
        chk("e1_inst", w_inst0, 32'hE3A0_0001);
        chk("e1_pc4",  w_pc4_0, 32'd4);
        chk("wrap_pc",  w_pc1,   32'h0);
        chk("wrap_pc4", w_pc4_1, 32'h0);
        adv(2);
        chk("e3_pc",  w_pc0, 32'd12);
        chk("e3_cnt", {16'b0, w_cnt0}, 32'd3);
        adv(2);
        chk("sat_cnt", {30'b0, w_cnt1}, 32'd3);

        // Stall hold at pc=8 with W1 in IF/ID.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        adv(2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_pc",   w_pc0,   32'd8);
        chk("stall_inst", w_inst0, 32'hE3A0_1002);
        adv(1);
        chk("rel_inst", w_inst0, 32'hE081_2000);
        chk("rel_pc",   w_pc0,   32'd12);

        // Redirect from pc=20 to misaligned target 6.
        adv(2);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0006);
        chk("br_pc",   w_pc0,   32'd4);
        chk("br_inst", w_inst0, 32'h0);
        adv(1);
        chk("br_next", w_inst0, 32'hE3A0_1002);

        // Stall and branch together hold; branch alone then redirects.
        adv(2);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        chk("sb_pc", w_pc0, 32'd16);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        chk("sb_redir", w_pc0, 32'h40);

        // Reset overrides stall and branch.
        adv(1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        chk("mid_rst_pc", w_pc0, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline; sits directly upstream of the decode/control-unit stage and owns the PC and the IF/ID boundary.
- Holds the PC, drives the instruction-memory address and computes PC+4.
- Latches the fetched word and its PC+4 into the IF/ID register.
- Supports a stall from hazard detection and a taken-branch redirect from ID; a redirect squashes the wrong-path fetch into a NOP (all-zero word).

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC and IF/ID contents this cycle (load-use hazard).
- br_taken  input  1  branch in ID resolved taken this cycle.
- br_target  input  32  branch target byte address.
- imem_data  input  32  instruction word from combinational instruction RAM.
- imem_addr  output  32  instruction RAM address; equals pc.
- pc  output  32  current PC.
- ifid_inst  output  32  IF/ID instruction word; all zeros means NOP.
- ifid_pc4  output  32  PC+4 of the instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real fetched instruction.
- fetch_count  output  CNT_W  number of instructions accepted into IF/ID, saturating.

Behaviour:
- imem_addr = pc, purely combinational. The fetched word is imem_data in the same cycle; the memory has no latency.
- Reset (CLR=1 at a posedge) has top priority over all other inputs:
  - pc <= RESET_PC
  - ifid_inst <= 0
  - ifid_pc4 <= 0
  - ifid_valid <= 0
  - fetch_count <= 0
- A reset asserted mid-operation discards any in-flight instruction and branch. The first post-reset fetch uses RESET_PC at the first edge with CLR=0.
- Priority per edge when CLR=0:
  - (1) br_taken=1 and stall=0 (REDIRECT): pc <= {br_target[31:2],2'b00}. ifid_inst <= 0, ifid_valid <= 0, ifid_pc4 <= 0. fetch_count unchanged. The wrong-path word on imem_data is dropped.
  - (2) stall=1 (HOLD): pc, ifid_inst, ifid_pc4, ifid_valid and fetch_count all keep their values. br_taken is ignored, because the branch in ID is itself stalled and not final.
  - (3) otherwise (ADVANCE): pc <= pc+4. ifid_inst <= imem_data, ifid_pc4 <= pc+4, ifid_valid <= 1. fetch_count <= fetch_count+1, saturating at all-ones.
- Arithmetic: pc+4 is computed modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- br_target bits [1:0] are always forced to zero.
- A NOP is just a zero word: a zero imem_data on ADVANCE sets ifid_valid=1 and is counted.
- No output changes except at a clock edge; there is no asynchronous path through the stage apart from imem_addr.
- Effective redirect latency: a branch resolved in ID in cycle n causes the target to be fetched in cycle n+1. Exactly one bubble enters IF/ID.

Test Plan:
- Reset then free-run: CLR high for 2 edges, then low, with imem holding words W0,W1,W2 at 0,4,8.
  - After edge 1: pc=4, ifid_inst=W0, ifid_pc4=4, valid=1.
  - After edge 3: pc=12, fetch_count=3.
- Stall hold: with pc=8 and ifid_inst=W1, assert stall for 2 cycles.
  - pc stays 8, ifid_inst stays W1, fetch_count unchanged.
  - After release, the next edge loads W2 and sets pc=12.
- Branch redirect: with pc=20, pulse br_taken with br_target=32'h00000006.
  - Next edge: pc=4, ifid_inst=0, ifid_valid=0, ifid_pc4=0.
  - The following edge loads the word at address 4.
- Simultaneous stall+br_taken: with pc=16, assert both for one cycle.
  - State is fully held (pc=16).
  - Then br_taken alone redirects on the next edge.
- Reset mid-operation and wrap/saturation:
  - CLR pulsed while stall=1 and br_taken=1: pc=RESET_PC, IF/ID cleared.
  - With RESET_PC=32'hFFFFFFFC: one ADVANCE gives pc=0 and ifid_pc4=0.
  - With CNT_W=2: after 5 ADVANCE cycles fetch_count=3.
